// File: rtl/ina219_poll_sequencer_if.sv
// ----------------------------------------------------------------------------
// ina219_poll_sequencer_if
// Command/response bundle between the INA219 poll sequencer and the I2C master.
//   i2c_busy        master -> seq   master is executing a transaction
//   i2c_done        master -> seq   1-cycle transaction_done pulse
//   i2c_ack_error   master -> seq   NACK seen, valid with i2c_done
//   i2c_read_data   master -> seq   16-bit read result, valid with i2c_done
//   i2c_start       seq -> master   1-cycle start pulse
//   i2c_rw          seq -> master   0 = write, 1 = read
//   i2c_reg_pointer seq -> master   INA219 register pointer
//   i2c_write_data  seq -> master   16-bit write payload
// Modports: master = sequencer side (drives commands), slave = I2C master side.
// ----------------------------------------------------------------------------
interface ina219_poll_sequencer_if;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_ack_error;
    logic [15:0] i2c_read_data;
    logic        i2c_start;
    logic        i2c_rw;
    logic [7:0]  i2c_reg_pointer;
    logic [15:0] i2c_write_data;

    modport master (
        input  i2c_busy, i2c_done, i2c_ack_error, i2c_read_data,
        output i2c_start, i2c_rw, i2c_reg_pointer, i2c_write_data
    );

    modport slave (
        output i2c_busy, i2c_done, i2c_ack_error, i2c_read_data,
        input  i2c_start, i2c_rw, i2c_reg_pointer, i2c_write_data
    );
endinterface

// File: rtl/ina219_poll_sequencer.sv
// ----------------------------------------------------------------------------
// ina219_poll_sequencer
// Drives the I2C master's command inputs: after enable it writes the INA219
// configuration (reg 0x00) and calibration (reg 0x05) registers, then on every
// sample tick polls shunt voltage, bus voltage, power and current (regs
// 0x01..0x04, pointer write followed by read each) and publishes the four
// words together with a one-cycle sample_valid pulse.
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_enable                1 = init then poll, 0 = go idle after current transaction
//   io_i2c (master modport) command/response bundle to the I2C master
//   o_shunt_v/o_bus_v/o_power/o_current  last published sample set
//   o_sample_valid          1-cycle pulse when the four outputs update
//   o_init_done             config + calibration written
//   o_overrun               sticky, tick arrived while a set was in progress
//   o_fault                 sticky, retries or timeout exhausted
// ----------------------------------------------------------------------------
module ina219_poll_sequencer #(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          SAMPLE_HZ   = 100,
    parameter logic [15:0] CONFIG_VAL  = 16'h399F,
    parameter logic [15:0] CAL_VAL     = 16'h1000,
    parameter int          MAX_RETRY   = 3,
    parameter int          TIMEOUT_CYC = 100_000
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_enable,
    ina219_poll_sequencer_if.master        io_i2c,
    output logic [15:0]                    o_shunt_v,
    output logic [15:0]                    o_bus_v,
    output logic [15:0]                    o_power,
    output logic [15:0]                    o_current,
    output logic                           o_sample_valid,
    output logic                           o_init_done,
    output logic                           o_overrun,
    output logic                           o_fault
);

    localparam int TICK_CYC = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W   = $clog2(TICK_CYC + 2);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 2);
    localparam int RTY_W    = $clog2(MAX_RETRY + 2);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_WR,
        S_CAL_WR,
        S_WAIT_TICK,
        S_PTR_WR,
        S_RD,
        S_PUBLISH,
        S_FAULT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_outstanding;
    logic               r_start_q;
    logic [TMO_W-1:0]   r_timer;
    logic [RTY_W-1:0]   r_retry;
    logic [1:0]         r_idx;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               r_tick_pend;
    logic [15:0]        r_stage [4];
    logic [15:0]        r_shunt_v;
    logic [15:0]        r_bus_v;
    logic [15:0]        r_power;
    logic [15:0]        r_current;
    logic               r_sample_valid;
    logic               r_init_done;
    logic               r_overrun;
    logic               r_fault;

    logic               w_in_xact;
    logic               w_in_set;
    logic               w_xact_end;
    logic               w_ok;
    logic               w_tick;
    logic               w_start;
    logic               w_retry_inc;
    logic               w_rw;
    logic [7:0]         w_reg_ptr;
    logic [15:0]        w_wdata;

    assign w_in_xact  = (r_state == S_CFG_WR) || (r_state == S_CAL_WR) ||
                        (r_state == S_PTR_WR) || (r_state == S_RD);
    assign w_in_set   = (r_state == S_PTR_WR) || (r_state == S_RD) ||
                        (r_state == S_PUBLISH);
    // A transaction ends either on the master's done pulse or when the
    // timer reaches its last count without one; a timeout is a failure.
    assign w_xact_end = r_outstanding && (io_i2c.i2c_done || (r_timer == TMO_LAST));
    assign w_ok       = r_outstanding && io_i2c.i2c_done && !io_i2c.i2c_ack_error;
    assign w_tick     = r_init_done && (r_tick_cnt == TICK_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, start pulse and command fields
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_rw        = 1'b0;
        w_reg_ptr   = 8'h00;
        w_wdata     = 16'h0000;
        // Spacing rule: never while busy, never two cycles in a row.
        w_start     = w_in_xact && !r_outstanding && i_enable &&
                      !io_i2c.i2c_busy && !r_start_q;

        case (r_state)
            S_IDLE: begin
                if (i_enable) w_state_nxt = S_CFG_WR;
            end
            S_CFG_WR, S_CAL_WR, S_PTR_WR, S_RD: begin
                if (w_xact_end) begin
                    if (!i_enable) begin
                        // Disable: accept the outcome as-is, no retry.
                        w_state_nxt = S_IDLE;
                    end else if (w_ok) begin
                        case (r_state)
                            S_CFG_WR: w_state_nxt = S_CAL_WR;
                            S_CAL_WR: w_state_nxt = S_WAIT_TICK;
                            S_PTR_WR: w_state_nxt = S_RD;
                            default:  w_state_nxt = (r_idx == 2'd3) ? S_PUBLISH : S_PTR_WR;
                        endcase
                    end else if (r_retry < RTY_MAX) begin
                        w_retry_inc = 1'b1;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end else if (!r_outstanding && !i_enable) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_TICK: begin
                if (!i_enable)                  w_state_nxt = S_IDLE;
                else if (w_tick || r_tick_pend) w_state_nxt = S_PTR_WR;
            end
            S_PUBLISH: begin
                if (!i_enable)                  w_state_nxt = S_IDLE;
                else if (w_tick || r_tick_pend) w_state_nxt = S_PTR_WR;
                else                            w_state_nxt = S_WAIT_TICK;
            end
            S_FAULT: begin
                if (!i_enable) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Command fields follow the state, so they stay put until done.
        case (r_state)
            S_CFG_WR: begin
                w_reg_ptr = 8'h00;
                w_wdata   = CONFIG_VAL;
            end
            S_CAL_WR: begin
                w_reg_ptr = 8'h05;
                w_wdata   = CAL_VAL;
            end
            S_PTR_WR: begin
                w_reg_ptr = {6'b0, r_idx} + 8'd1;
            end
            S_RD: begin
                w_rw      = 1'b1;
                w_reg_ptr = {6'b0, r_idx} + 8'd1;
            end
            default: begin
                w_rw      = 1'b0;
            end
        endcase
    end

    // Transaction tracking, staging, publishing and status flags
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_outstanding  <= 1'b0;
            r_start_q      <= 1'b0;
            r_timer        <= '0;
            r_retry        <= '0;
            r_idx          <= 2'd0;
            r_tick_cnt     <= '0;
            r_tick_pend    <= 1'b0;
            for (int k = 0; k < 4; k++) r_stage[k] <= 16'h0000;
            r_shunt_v      <= 16'h0000;
            r_bus_v        <= 16'h0000;
            r_power        <= 16'h0000;
            r_current      <= 16'h0000;
            r_sample_valid <= 1'b0;
            r_init_done    <= 1'b0;
            r_overrun      <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_start_q <= w_start;

            if (w_start) begin
                r_outstanding <= 1'b1;
                r_timer       <= '0;
            end else if (w_xact_end) begin
                r_outstanding <= 1'b0;
            end else if (r_outstanding) begin
                r_timer <= r_timer + TMO_W'(1);
            end

            // Every success moves the FSM on, so a state change clears retries.
            if (w_state_nxt != r_state) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RTY_W'(1);
            end

            if ((r_state == S_RD) && w_ok) begin
                r_stage[r_idx] <= io_i2c.i2c_read_data;
                r_idx          <= r_idx + 2'd1;
            end else if (!((r_state == S_PTR_WR) || (r_state == S_RD))) begin
                r_idx <= 2'd0;
            end

            r_sample_valid <= (r_state == S_PUBLISH);
            if (r_state == S_PUBLISH) begin
                r_shunt_v <= r_stage[0];
                r_bus_v   <= r_stage[1];
                r_power   <= r_stage[2];
                r_current <= r_stage[3];
            end

            if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FAULT)) begin
                r_init_done <= 1'b0;
            end else if ((r_state == S_CAL_WR) && w_ok) begin
                r_init_done <= 1'b1;
            end

            if (w_state_nxt == S_IDLE) begin
                r_fault <= 1'b0;
            end else if (w_state_nxt == S_FAULT) begin
                r_fault <= 1'b1;
            end

            if (w_state_nxt == S_IDLE) begin
                r_overrun <= 1'b0;
            end else if (w_tick && w_in_set) begin
                r_overrun <= 1'b1;
            end

            // At most one tick is remembered; PUBLISH always consumes it.
            if ((w_state_nxt == S_IDLE) || (r_state == S_PUBLISH)) begin
                r_tick_pend <= 1'b0;
            end else if (w_tick && w_in_set) begin
                r_tick_pend <= 1'b1;
            end

            // Held at zero while not initialised, so the first tick lands a
            // full period after init_done rises.
            if (!r_init_done || (r_tick_cnt == TICK_LAST)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

    assign io_i2c.i2c_start       = w_start;
    assign io_i2c.i2c_rw          = w_rw;
    assign io_i2c.i2c_reg_pointer = w_reg_ptr;
    assign io_i2c.i2c_write_data  = w_wdata;

    assign o_shunt_v      = r_shunt_v;
    assign o_bus_v        = r_bus_v;
    assign o_power        = r_power;
    assign o_current      = r_current;
    assign o_sample_valid = r_sample_valid;
    assign o_init_done    = r_init_done;
    assign o_overrun      = r_overrun;
    assign o_fault        = r_fault;

endmodule

// File: tb/tb_ina219_poll_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ina219_poll_sequencer
// Directed bench for ina219_poll_sequencer with a behavioural I2C master that
// logs every start and answers after a programmable latency.
// ----------------------------------------------------------------------------
module tb_ina219_poll_sequencer;
    localparam int CLK_HZ      = 1000;
    localparam int SAMPLE_HZ   = 5;      // 200-cycle tick
    localparam int MAX_RETRY   = 3;
    localparam int TIMEOUT_CYC = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] shunt_v, bus_v, power, current;
    logic        sample_valid, init_done, overrun, fault;

    ina219_poll_sequencer_if bus ();

    ina219_poll_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_HZ   (SAMPLE_HZ),
        .CONFIG_VAL  (16'h399F),
        .CAL_VAL     (16'h1000),
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_enable       (enable),
        .io_i2c         (bus),
        .o_shunt_v      (shunt_v),
        .o_bus_v        (bus_v),
        .o_power        (power),
        .o_current      (current),
        .o_sample_valid (sample_valid),
        .o_init_done    (init_done),
        .o_overrun      (overrun),
        .o_fault        (fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Master model state and transaction log
    int          lat = 2;
    bit          no_resp = 1'b0;
    bit          err_cal_once = 1'b0;
    bit          err_rd2 = 1'b0;
    logic [15:0] rd_val [0:7];
    bit          m_act = 1'b0;
    int          m_cnt = 0;
    logic        m_rw;
    logic [7:0]  m_ptr;

    logic        log_rw  [64];
    logic [7:0]  log_ptr [64];
    logic [15:0] log_wd  [64];
    int          log_cyc [64];
    int          log_n = 0;

    int          sv_cnt = 0;
    int          sv_cyc = 0;

    always @(negedge clk) begin
        bus.i2c_done      = 1'b0;
        bus.i2c_ack_error = 1'b0;
        if (m_act) begin
            if (m_cnt == 0) begin
                bus.i2c_done      = 1'b1;
                bus.i2c_busy      = 1'b0;
                bus.i2c_read_data = m_rw ? rd_val[m_ptr[2:0]] : 16'h0000;
                if (err_rd2 && m_rw && (m_ptr == 8'h02)) bus.i2c_ack_error = 1'b1;
                if (err_cal_once && !m_rw && (m_ptr == 8'h05)) begin
                    bus.i2c_ack_error = 1'b1;
                    err_cal_once      = 1'b0;
                end
                m_act = 1'b0;
            end else begin
                bus.i2c_busy = 1'b1;
                m_cnt--;
            end
        end
        if (bus.i2c_start === 1'b1) begin
            if (log_n < 64) begin
                log_rw[log_n]  = bus.i2c_rw;
                log_ptr[log_n] = bus.i2c_reg_pointer;
                log_wd[log_n]  = bus.i2c_write_data;
                log_cyc[log_n] = cyc;
            end
            log_n++;
            if (!no_resp) begin
                m_act = 1'b1;
                m_cnt = lat;
                m_rw  = bus.i2c_rw;
                m_ptr = bus.i2c_reg_pointer;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            sv_cnt++;
            sv_cyc = cyc;
        end
    end

    // Data outputs may only change in a sample_valid cycle (reset excepted).
    logic [63:0] prev_outs = 64'h0;
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            prev_outs = {shunt_v, bus_v, power, current};
        end else if ({shunt_v, bus_v, power, current} !== prev_outs) begin
            checks++;
            assert (sample_valid === 1'b1) else begin
                failures++;
                $error("FAIL out_change_without_valid observed sample_valid=%b expected=1 outs=%h", sample_valid, {shunt_v, bus_v, power, current});
            end
            prev_outs = {shunt_v, bus_v, power, current};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((log_n < n) && (k < budget)) begin
            wait_cyc(1);
            k++;
        end
        chk(tag, 32'(log_n >= n), 32'd1);
    endtask

    task automatic wait_sv(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((sv_cnt < n) && (k < budget)) begin
            wait_cyc(1);
            k++;
        end
        chk(tag, 32'(sv_cnt >= n), 32'd1);
    endtask

    task automatic settle(input string tag);
        int k;
        enable = 1'b0;
        k = 0;
        while (m_act && (k < 200)) begin
            wait_cyc(1);
            k++;
        end
        chk(tag, 32'(m_act), 32'd0);
        wait_cyc(3);
        log_n  = 0;
        sv_cnt = 0;
    endtask

    initial begin
        int n0;
        reset_n           = 1'b0;
        enable            = 1'b0;
        bus.i2c_busy      = 1'b0;
        bus.i2c_done      = 1'b0;
        bus.i2c_ack_error = 1'b0;
        bus.i2c_read_data = 16'h0000;
        for (int i = 0; i < 8; i++) rd_val[i] = 16'h0000;
        rd_val[1] = 16'h1111;
        rd_val[2] = 16'h2222;
        rd_val[3] = 16'h3333;
        rd_val[4] = 16'h4444;

        // Reset state
        wait_cyc(3);
        chk("rst_start", 32'(bus.i2c_start), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_shunt_v", 32'(shunt_v), 32'd0);
        reset_n = 1'b1;
        wait_cyc(2);

        // 1: full init and one sample set
        lat    = 2;
        enable = 1'b1;
        wait_sv(1, 600, "t1_sv_wait");
        chk("t1_cfg", {log_rw[0], log_ptr[0], log_wd[0]}, {1'b0, 8'h00, 16'h399F});
        chk("t1_cal", {log_rw[1], log_ptr[1], log_wd[1]}, {1'b0, 8'h05, 16'h1000});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_poll%0d", i), {log_rw[2+i], log_ptr[2+i]}, {1'(i % 2), 8'(i / 2 + 1)});
        end
        wait_cyc(20);
        chk("t1_shunt_v", 32'(shunt_v), 32'h1111);
        chk("t1_bus_v", 32'(bus_v), 32'h2222);
        chk("t1_power", 32'(power), 32'h3333);
        chk("t1_current", 32'(current), 32'h4444);
        chk("t1_sv_count", 32'(sv_cnt), 32'd1);
        chk("t1_init_done", 32'(init_done), 32'd1);
        chk("t1_overrun", 32'(overrun), 32'd0);
        settle("t1_settle");

        // 2: NACK on first calibration write
        err_cal_once = 1'b1;
        enable       = 1'b1;
        wait_log(5, 400, "t2_log_wait");
        chk("t2_cal_try1", {log_rw[1], log_ptr[1], log_wd[1]}, {1'b0, 8'h05, 16'h1000});
        chk("t2_cal_try2", {log_rw[2], log_ptr[2], log_wd[2]}, {1'b0, 8'h05, 16'h1000});
        chk("t2_next_ptr", {log_rw[3], log_ptr[3]}, {1'b0, 8'h01});
        chk("t2_fault", 32'(fault), 32'd0);
        chk("t2_init_done", 32'(init_done), 32'd1);
        settle("t2_settle");

        // 3: every read of reg 0x02 NACKed
        err_rd2 = 1'b1;
        enable  = 1'b1;
        wait_log(9, 800, "t3_log_wait");
        wait_cyc(100);
        chk("t3_start_count", 32'(log_n), 32'd9);
        chk("t3_ptr2", {log_rw[4], log_ptr[4]}, {1'b0, 8'h02});
        for (int i = 5; i < 9; i++) begin
            chk($sformatf("t3_rd2_try%0d", i - 4), {log_rw[i], log_ptr[i]}, {1'b1, 8'h02});
        end
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_init_done", 32'(init_done), 32'd0);
        chk("t3_no_sv", 32'(sv_cnt), 32'd0);
        err_rd2 = 1'b0;
        settle("t3_settle");
        chk("t3_fault_cleared", 32'(fault), 32'd0);

        // 4: master never answers
        no_resp = 1'b1;
        enable  = 1'b1;
        wait_log(4, 400, "t4_log_wait");
        wait_cyc(100);
        chk("t4_start_count", 32'(log_n), 32'd4);
        chk("t4_retry_cmd", {log_rw[3], log_ptr[3], log_wd[3]}, {1'b0, 8'h00, 16'h399F});
        chk("t4_timeout_gap", 32'(log_cyc[1] - log_cyc[0]), 32'(TIMEOUT_CYC + 1));
        chk("t4_fault", 32'(fault), 32'd1);
        no_resp = 1'b0;
        settle("t4_settle");

        // 5: set longer than the tick period
        lat       = 30;
        rd_val[1] = 16'hA001;
        rd_val[2] = 16'hA002;
        rd_val[3] = 16'hA003;
        rd_val[4] = 16'hA004;
        enable    = 1'b1;
        wait_sv(2, 2000, "t5_sv_wait");
        chk("t5_overrun", 32'(overrun), 32'd1);
        chk("t5_shunt_v", 32'(shunt_v), 32'hA001);
        chk("t5_current", 32'(current), 32'hA004);
        chk("t5_b2b_ptr", {log_rw[log_n-1], log_ptr[log_n-1]}, {1'b0, 8'h01});
        chk("t5_b2b_cycle", 32'(log_cyc[log_n-1]), 32'(sv_cyc));
        settle("t5_settle");
        chk("t5_overrun_cleared", 32'(overrun), 32'd0);

        // 6: disable mid-read, re-enable, then reset mid-transaction
        lat    = 20;
        enable = 1'b1;
        wait_log(4, 600, "t6_log_wait");
        chk("t6_rd_started", {log_rw[3], log_ptr[3]}, {1'b1, 8'h01});
        wait_cyc(3);
        enable = 1'b0;
        n0     = log_n;
        wait_cyc(1);
        chk("t6_init_done_held", 32'(init_done), 32'd1);
        begin
            int k;
            k = 0;
            while (m_act && (k < 100)) begin
                wait_cyc(1);
                k++;
            end
        end
        wait_cyc(3);
        chk("t6_init_done_low", 32'(init_done), 32'd0);
        wait_cyc(50);
        chk("t6_no_new_start", 32'(log_n), 32'(n0));
        chk("t6_shunt_hold", 32'(shunt_v), 32'hA001);
        chk("t6_power_hold", 32'(power), 32'hA003);
        log_n  = 0;
        enable = 1'b1;
        wait_log(1, 50, "t6_reenable_wait");
        chk("t6_reenable_cfg", {log_rw[0], log_ptr[0], log_wd[0]}, {1'b0, 8'h00, 16'h399F});
        wait_cyc(3);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("t6_rst_wdata", 32'(bus.i2c_write_data), 32'd0);
        chk("t6_rst_start", 32'(bus.i2c_start), 32'd0);
        chk("t6_rst_shunt_v", 32'(shunt_v), 32'd0);
        chk("t6_rst_current", 32'(current), 32'd0);
        chk("t6_rst_init_done", 32'(init_done), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        wait_cyc(30);
        reset_n = 1'b1;
        wait_cyc(5);
        chk("t6_idle_after_rst", 32'(init_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
